// File: rtl/rs_dispatch_ctrl.sv
// rs_dispatch_ctrl: one-entry dispatch register between the decoder and the
// four reservation stations (ALU=0, SFU=1, BRU=2, AGU=3). Instructions are
// forwarded only when the target station has a free entry, tracked through
// per-station credit counters. A mispredict flush drops the held instruction
// and restores all credits.
// Optional macro RS_DISPATCH_PERF_EN adds stall_cycles/dispatch_count outputs.
module rs_dispatch_ctrl #(
  parameter int RS_DEPTH = 4,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_valid,
  output logic        de_ready,
  input  logic        de_rs_write,
  input  logic [1:0]  de_rs_num,
  input  logic [3:0]  de_ctrl,
  input  logic [31:0] de_imm,
  output logic [3:0]  ds_valid,
  output logic [3:0]  ds_ctrl,
  output logic [31:0] ds_imm,
  input  logic [3:0]  rs_release,
  input  logic        flush,
  output logic        credit_err
`ifdef RS_DISPATCH_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] dispatch_count
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(RS_DEPTH);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] credit [4];

  logic             h_v;
  logic [1:0]       h_num;
  logic [3:0]       h_ctrl;
  logic [31:0]      h_imm;

  logic             h_has_credit;
  logic             fire;
  logic             acc;
  logic             load;
  logic [3:0]       fire_vec;
  logic [3:0]       rel_vec;
  logic [3:0]       err_vec;

  assign h_has_credit = (credit[h_num] != '0);
  assign fire         = h_v & h_has_credit & ~flush;
  assign ds_valid     = fire_vec;
  assign de_ready     = rst_n & ~flush & (state != RECOVER) & (~h_v | fire);
  assign acc          = de_valid & de_ready;
  assign load         = acc & de_rs_write;

  // H fields only change on a load, so they already hold the last value
  assign ds_ctrl = h_ctrl;
  assign ds_imm  = h_imm;

  // One-hot strobe toward the selected station when the held entry leaves
  always_comb begin
    fire_vec = 4'b0000;
    if (fire) fire_vec = 4'b0001 << h_num;
  end

  // Usable releases versus releases arriving at an already-full counter
  always_comb begin
    rel_vec = 4'b0000;
    err_vec = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rel_vec[i] = rs_release[i] & ~flush & (credit[i] != FULL);
      err_vec[i] = rs_release[i] & ~flush & (credit[i] == FULL);
    end
  end

  // Credit counters: take one on dispatch, give one back on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) credit[i] <= FULL;
    end else if (flush) begin
      for (int i = 0; i < 4; i++) credit[i] <= FULL;
    end else begin
      for (int i = 0; i < 4; i++)
        credit[i] <= credit[i] - CNT_W'(fire_vec[i]) + CNT_W'(rel_vec[i]);
    end
  end

  // Holding register: load on accept, empty once dispatched or flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_v    <= 1'b0;
      h_num  <= 2'd0;
      h_ctrl <= 4'd0;
      h_imm  <= 32'd0;
    end else if (flush) begin
      h_v <= 1'b0;
    end else if (load) begin
      h_v    <= 1'b1;
      h_num  <= de_rs_num;
      h_ctrl <= de_ctrl;
      h_imm  <= de_imm;
    end else if (fire) begin
      h_v <= 1'b0;
    end
  end

  // Sticky error for a release that had no entry to return to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           credit_err <= 1'b0;
    else if (|err_vec)    credit_err <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state: flush wins, RECOVER lasts a single cycle
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RECOVER;
    end else begin
      case (state)
        RUN:     if (h_v & ~h_has_credit) state_nxt = STALL;
        STALL:   if (fire)                state_nxt = RUN;
        RECOVER:                          state_nxt = RUN;
        default:                          state_nxt = RUN;
      endcase
    end
  end

`ifdef RS_DISPATCH_PERF_EN
  // Performance counters, untouched by flush, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles   <= 32'd0;
      dispatch_count <= 32'd0;
    end else begin
      if (h_v & ~fire & ~flush) stall_cycles <= stall_cycles + 32'd1;
      if (fire)                 dispatch_count <= dispatch_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_dispatch_ctrl.sv
// Testbench for rs_dispatch_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model of the dispatch/credit rules.
module tb_rs_dispatch_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de_valid = 1'b0;
  logic        de_ready;
  logic        de_rs_write = 1'b0;
  logic [1:0]  de_rs_num = 2'd0;
  logic [3:0]  de_ctrl = 4'd0;
  logic [31:0] de_imm = 32'd0;
  logic [3:0]  ds_valid;
  logic [3:0]  ds_ctrl;
  logic [31:0] ds_imm;
  logic [3:0]  rs_release = 4'd0;
  logic        flush = 1'b0;
  logic        credit_err;
`ifdef RS_DISPATCH_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] dispatch_count;
`endif

  int checks = 0;
  int errors = 0;

  rs_dispatch_ctrl #(.RS_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .de_valid    (de_valid),
    .de_ready    (de_ready),
    .de_rs_write (de_rs_write),
    .de_rs_num   (de_rs_num),
    .de_ctrl     (de_ctrl),
    .de_imm      (de_imm),
    .ds_valid    (ds_valid),
    .ds_ctrl     (ds_ctrl),
    .ds_imm      (ds_imm),
    .rs_release  (rs_release),
    .flush       (flush),
    .credit_err  (credit_err)
`ifdef RS_DISPATCH_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .dispatch_count (dispatch_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [1:0] num,
                               input logic [3:0] ctrl, input logic [31:0] imm,
                               input logic [3:0] rel, input logic f);
    @(posedge clk);
    #1;
    de_valid    = v;
    de_rs_write = w;
    de_rs_num   = num;
    de_ctrl     = ctrl;
    de_imm      = imm;
    rs_release  = rel;
    flush       = f;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    de_valid = 1'b0; de_rs_write = 1'b0; de_rs_num = 2'd0;
    de_ctrl = 4'd0; de_imm = 32'd0; rs_release = 4'd0; flush = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Behavioural model: what the station interface must look like
  int          m_cred [4];
  bit          m_hv;
  int          m_hnum;
  logic [3:0]  m_hctrl;
  logic [31:0] m_himm;
  bit          m_err;
  bit          m_recover;
  logic [31:0] m_stall;
  logic [31:0] m_disp;

  always @(negedge clk) begin
    bit         can_send;
    bit         e_ready;
    logic [3:0] e_valid;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_cred[i] = DEPTH;
      m_hv = 0; m_hnum = 0; m_hctrl = 4'd0; m_himm = 32'd0;
      m_err = 0; m_recover = 0; m_stall = 32'd0; m_disp = 32'd0;
      checkOutput("rst_de_ready", {31'd0, de_ready}, 32'd0);
      checkOutput("rst_ds_valid", {28'd0, ds_valid}, 32'd0);
      checkOutput("rst_ds_ctrl", {28'd0, ds_ctrl}, 32'd0);
      checkOutput("rst_ds_imm", ds_imm, 32'd0);
      checkOutput("rst_credit_err", {31'd0, credit_err}, 32'd0);
    end else begin
      can_send = m_hv && (m_cred[m_hnum] > 0) && !flush;
      e_valid  = can_send ? 4'(1 << m_hnum) : 4'd0;
      e_ready  = !flush && !m_recover && (!m_hv || can_send);
      checkOutput("model_ds_valid", {28'd0, ds_valid}, {28'd0, e_valid});
      checkOutput("model_de_ready", {31'd0, de_ready}, {31'd0, e_ready});
      checkOutput("model_ds_ctrl", {28'd0, ds_ctrl}, {28'd0, m_hctrl});
      checkOutput("model_ds_imm", ds_imm, m_himm);
      checkOutput("model_credit_err", {31'd0, credit_err}, {31'd0, m_err});
`ifdef RS_DISPATCH_PERF_EN
      checkOutput("model_stall_cycles", stall_cycles, m_stall);
      checkOutput("model_dispatch_count", dispatch_count, m_disp);
      if (m_hv && !can_send && !flush) m_stall = m_stall + 32'd1;
      if (can_send) m_disp = m_disp + 32'd1;
`endif
      if (flush) begin
        for (int i = 0; i < 4; i++) m_cred[i] = DEPTH;
        m_hv = 0;
        m_recover = 1;
      end else begin
        m_recover = 0;
        if (can_send) m_cred[m_hnum] = m_cred[m_hnum] - 1;
        for (int i = 0; i < 4; i++) begin
          if (rs_release[i]) begin
            // release is judged against the count before this edge
            if ((m_cred[i] + ((can_send && m_hnum == i) ? 1 : 0)) == DEPTH) m_err = 1;
            else m_cred[i] = m_cred[i] + 1;
          end
        end
        if (de_valid && e_ready && de_rs_write) begin
          m_hv = 1; m_hnum = int'(de_rs_num); m_hctrl = de_ctrl; m_himm = de_imm;
        end else if (can_send) begin
          m_hv = 0;
        end
      end
    end
  end

  initial begin
    doReset();

    // Single dispatch to BRU
    applyStimulus(1'b1, 1'b1, 2'd2, 4'h3, 32'h100, 4'd0, 1'b0);
    @(negedge clk); checkOutput("single_ready", {31'd0, de_ready}, 32'd1);
    idle();
    @(negedge clk);
    checkOutput("single_valid", {28'd0, ds_valid}, 32'b0100);
    checkOutput("single_ctrl", {28'd0, ds_ctrl}, 32'h3);
    checkOutput("single_imm", ds_imm, 32'h100);

    // Credit exhaustion on ALU
    doReset();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b1, 2'd0, 4'(k), 32'(k * 16), 4'd0, 1'b0);
      @(negedge clk);
      checkOutput("exh_ready", {31'd0, de_ready}, 32'd1);
      checkOutput("exh_valid", {28'd0, ds_valid}, (k == 1) ? 32'd0 : 32'b0001);
    end
    idle();
    @(negedge clk);
    checkOutput("exh_held_valid", {28'd0, ds_valid}, 32'd0);
    checkOutput("exh_held_ready", {31'd0, de_ready}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 4'b0001, 1'b0);
    @(negedge clk);
    checkOutput("exh_nobypass", {28'd0, ds_valid}, 32'd0);
    idle();
    @(negedge clk);
    checkOutput("exh_resume_valid", {28'd0, ds_valid}, 32'b0001);
    checkOutput("exh_resume_ctrl", {28'd0, ds_ctrl}, 32'h5);
    checkOutput("exh_resume_ready", {31'd0, de_ready}, 32'd1);

    // Non-RS instruction
    doReset();
    applyStimulus(1'b1, 1'b0, 2'd1, 4'h7, 32'hABCD, 4'd0, 1'b0);
    @(negedge clk); checkOutput("lui_ready", {31'd0, de_ready}, 32'd1);
    idle();
    @(negedge clk); checkOutput("lui_novalid", {28'd0, ds_valid}, 32'd0);

    // Fire and release together on AGU at credit 2
    doReset();
    applyStimulus(1'b1, 1'b1, 2'd3, 4'h1, 32'd1, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd3, 4'h2, 32'd2, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd3, 4'h3, 32'd3, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 32'd0, 4'b1000, 1'b0);
    @(negedge clk); checkOutput("agu_fire", {28'd0, ds_valid}, 32'b1000);
    applyStimulus(1'b1, 1'b1, 2'd3, 4'h4, 32'd4, 4'd0, 1'b0);
    @(negedge clk); checkOutput("agu_err", {31'd0, credit_err}, 32'd0);
    applyStimulus(1'b1, 1'b1, 2'd3, 4'h5, 32'd5, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd3, 4'h6, 32'd6, 4'd0, 1'b0);
    @(negedge clk); checkOutput("agu_last_credit", {28'd0, ds_valid}, 32'b1000);
    idle();
    @(negedge clk); checkOutput("agu_empty", {28'd0, ds_valid}, 32'd0);

    // Flush with SFU entry held and credit 1
    doReset();
    for (int k = 1; k <= 4; k++)
      applyStimulus(1'b1, 1'b1, 2'd1, 4'(k), 32'(k), 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("flush_valid", {28'd0, ds_valid}, 32'd0);
    checkOutput("flush_ready", {31'd0, de_ready}, 32'd0);
    idle();
    @(negedge clk); checkOutput("recover_ready", {31'd0, de_ready}, 32'd0);
    applyStimulus(1'b1, 1'b1, 2'd1, 4'h9, 32'h99, 4'd0, 1'b0);
    @(negedge clk); checkOutput("post_flush_ready", {31'd0, de_ready}, 32'd1);
    idle();
    @(negedge clk);
    checkOutput("post_flush_valid", {28'd0, ds_valid}, 32'b0010);
    checkOutput("post_flush_ctrl", {28'd0, ds_ctrl}, 32'h9);

    // Spurious release on SFU
    doReset();
    applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 4'b0010, 1'b0);
    @(negedge clk); checkOutput("spur_err_before", {31'd0, credit_err}, 32'd0);
    idle();
    @(negedge clk); checkOutput("spur_err_set", {31'd0, credit_err}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 4'd0, 1'b1);
    idle();
    @(negedge clk); checkOutput("spur_err_after_flush", {31'd0, credit_err}, 32'd1);
    doReset();
    @(negedge clk); checkOutput("spur_err_reset", {31'd0, credit_err}, 32'd0);

    // Randomized traffic with occasional flushes and mid-run resets
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 699) begin
        doReset();
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                      2'($urandom_range(0, 3)), 4'($urandom), $urandom,
                      4'($urandom) & 4'($urandom) & 4'($urandom),
                      $urandom_range(0, 29) == 0);
      end
    end
    idle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_dispatch_ctrl.md
Name: rs_dispatch_ctrl

Overview:
Dispatch scheduler between the instruction decoder and the four reservation stations: ALU=0, SFU=1, BRU=2, AGU=3.
- Takes one decoded instruction per cycle through a valid/ready handshake and holds it in a one-entry dispatch register.
- Forwards it to the station selected by de_rs_num, but only when that station has a free entry.
- Tracks free entries with per-station credit counters and clears all in-flight dispatch state on a branch-mispredict flush.

Parameters:
RS_DEPTH, 4, entries per reservation station; this is the credit counter reset value.
CNT_W, 3, credit counter width; must be at least clog2(RS_DEPTH+1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
de_valid  in  1  decoder presents an instruction.
de_ready  out  1  controller accepts the instruction this cycle.
de_rs_write  in  1  instruction needs a reservation station.
de_rs_num  in  2  target station index.
de_ctrl  in  4  FU control code.
de_imm  in  32  immediate or target PC.
ds_valid  out  4  one-hot dispatch strobe, one bit per station.
ds_ctrl  out  4  ctrl field of the dispatched instruction.
ds_imm  out  32  imm field of the dispatched instruction.
rs_release  in  4  per-station pulse: one entry freed this cycle.
flush  in  1  mispredict flush; stations are cleared externally in the same cycle.
credit_err  out  1  sticky flag: a release arrived while that station's credit was already RS_DEPTH.

Behaviour:
Reset (rst_n=0, asynchronous):
- state=RUN, h_v=0, all credits=RS_DEPTH, credit_err=0.
- ds_ctrl=0, ds_imm=0.
- ds_valid=0, de_ready=0 while rst_n is low.

Holding register H holds h_v, h_num, h_ctrl, h_imm.

Dispatch:
- fire = h_v & (credit[h_num]!=0) & ~flush.
- ds_valid = fire ? onehot(h_num) : 0 (combinational).
- ds_ctrl and ds_imm are driven from H whenever h_v=1; otherwise they hold their last value.

Accept:
- de_ready = ~flush & (state!=RECOVER) & (~h_v | fire).
- acc = de_valid & de_ready.
- On acc with de_rs_write=1: load H and set h_v=1.
- On acc with de_rs_write=0: the instruction is consumed; H is not loaded and there is no dispatch.
- If fire and no load into H: h_v clears.
- Minimum latency is one cycle: an instruction accepted at cycle N dispatches at cycle N+1 if credit is available.

Credits, per station i, at each clock edge:
- credit[i] <= credit[i] - fire_i + rel_i, where rel_i = rs_release[i] & (credit[i]!=RS_DEPTH).
- Release and fire in the same cycle leave the count unchanged.
- A release at credit==RS_DEPTH is dropped and sets credit_err=1.
- A release becomes usable the next cycle; there is no same-cycle bypass.
- Counters never underflow, because fire requires credit!=0.

State machine:
- RUN -> STALL when h_v & credit[h_num]==0.
- STALL -> RUN when fire.
- RUN or STALL -> RECOVER on flush.
- RECOVER -> RUN after exactly one cycle, unless flush is asserted again.
- STALL is informational; de_ready follows the formula above.

Flush (highest priority):
- In the flush cycle: ds_valid=0, de_ready=0, rs_release is ignored.
- Next edge: h_v=0, all credits=RS_DEPTH, state=RECOVER.
- RECOVER holds de_ready=0 for one cycle.
- credit_err is not cleared by flush; only reset clears it.

Reset mid-operation: everything returns to reset values immediately; a pending H entry is discarded.

Optional Feature:
RS_DISPATCH_PERF_EN
- Defined: adds output ports stall_cycles[31:0] and dispatch_count[31:0], both reset to 0.
  - stall_cycles increments each cycle with h_v & ~fire & ~flush.
  - dispatch_count increments on every fire.
  - Both wrap at 2^32; flush does not clear them.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single dispatch: after reset, de_valid=1, rs_write=1, rs_num=2, ctrl=4'h3, imm=32'h100 at cycle 0 -> ds_valid=4'b0100, ds_ctrl=3, ds_imm=32'h100 at cycle 1; credit[2]=3 at cycle 2.
- Credit exhaustion: 5 back-to-back ALU instructions, no release -> four dispatches on cycles 1-4; 5th held, de_ready=0, state=STALL; rs_release[0] pulse at cycle 6 -> ds_valid=4'b0001 at cycle 7.
- Non-RS instruction: rs_write=0 (LUI) accepted -> de_ready=1, no ds_valid the next cycle, credits unchanged.
- Simultaneous fire and release on AGU at credit=2 -> credit stays 2, credit_err=0.
- Flush with H valid and credit[1]=1 -> ds_valid=0 in flush cycle, de_ready=0 for 2 cycles, then all credits=4, de_ready=1.
- Spurious release on SFU at credit=4 -> credit stays 4, credit_err=1 and remains 1 through a subsequent flush; cleared only by rst_n=0.
